// File: rtl/mmr_monitor_pkg.sv
// Shared constants, event record and saturating arithmetic
// for the voter mismatch monitor.
package mmr_monitor_pkg;

    localparam int N_SRC_D = 8;
    localparam int CNT_W_D = 16;
    localparam int TS_W_D  = 16;
    localparam int DEPTH_D = 8;
    localparam int SRC_W_D = $clog2(N_SRC_D);

    typedef struct packed {
        logic [SRC_W_D-1:0] src;
        logic [TS_W_D-1:0]  tstamp;
    } evt_t;

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max}) begin
            return max;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/mmr_event_fifo.sv
// First-word-fall-through event FIFO; head is readable
// whenever empty_o is low.
module mmr_event_fifo
    import mmr_monitor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEPTH_D
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     full_o,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_cnt == (AW+1)'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign count_o = r_cnt;
    assign data_o  = r_mem[r_rd];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while non-empty.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= data_i;
    end

endmodule

// File: rtl/mmr_mismatch_monitor.sv
// Counts, flags and timestamps rising edges of voter mismatch lines
// and queues one event per upset for the slow-control readout.
module mmr_mismatch_monitor
    import mmr_monitor_pkg::*;
#(
    parameter int N_SRC = N_SRC_D,
    parameter int CNT_W = CNT_W_D,
    parameter int TS_W  = TS_W_D,
    parameter int DEPTH = DEPTH_D
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [N_SRC-1:0]         mismatch_i,
    input  logic                     clear_i,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic [$clog2(N_SRC)-1:0] evt_src_o,
    output logic [TS_W-1:0]          evt_time_o,
    output logic [CNT_W-1:0]         total_cnt_o,
    output logic [N_SRC-1:0]         sticky_o,
    output logic                     overflow_o
);

    localparam int SRC_W = $clog2(N_SRC);
    localparam int EW    = SRC_W + TS_W;
    localparam int PC_W  = $clog2(N_SRC + 1);

    logic [N_SRC-1:0]       r_m_q;
    logic [N_SRC-1:0]       r_pend;
    logic [N_SRC-1:0]       r_sticky;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf;
    logic [TS_W-1:0]        r_ts;

    logic [N_SRC-1:0]       w_rise;
    logic                   w_gnt_vld;
    logic [SRC_W-1:0]       w_gnt_idx;
    logic [N_SRC-1:0]       w_gnt_oh;
    logic [PC_W-1:0]        w_pc;
    logic [CNT_W-1:0]       w_cnt_base;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_ovf_evt;
    logic                   w_full;
    logic                   w_empty;
    logic [EW-1:0]          w_head;
    logic [$clog2(DEPTH):0] w_fcnt;

    assign w_rise = mismatch_i & ~r_m_q;

    // Descending scan so the lowest pending index wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (r_pend[i] && !w_full) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = SRC_W'(i);
            end
        end
        w_gnt_oh = w_gnt_vld ? (N_SRC'(1) << w_gnt_idx) : '0;
    end

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_rise[i]) w_pc = w_pc + PC_W'(1);
        end
    end

    assign w_cnt_base = clear_i ? '0 : r_cnt;
    assign w_cnt_nxt  = CNT_W'(sat_add(32'(w_cnt_base), 32'(w_pc),
                                       32'({CNT_W{1'b1}})));
    // A rise that cannot get its own entry merges into the pending one.
    assign w_ovf_evt  = |(w_rise & r_pend & ~w_gnt_oh);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_m_q    <= '0;
            r_pend   <= '0;
            r_sticky <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_ts     <= '0;
        end else begin
            r_m_q    <= mismatch_i;
            r_pend   <= (r_pend & ~w_gnt_oh) | w_rise;
            r_sticky <= clear_i ? w_rise : (r_sticky | w_rise);
            r_cnt    <= w_cnt_nxt;
            r_ovf    <= clear_i ? w_ovf_evt : (r_ovf | w_ovf_evt);
            r_ts     <= r_ts + 1'b1;
        end
    end

    mmr_event_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (w_gnt_vld),
        .data_i  ({w_gnt_idx, r_ts}),
        .full_o  (w_full),
        .pop_i   (evt_ready_i && (w_fcnt != '0)),
        .data_o  (w_head),
        .empty_o (w_empty),
        .count_o (w_fcnt)
    );

    assign evt_valid_o = ~w_empty;
    assign evt_src_o   = w_empty ? '0 : w_head[EW-1:TS_W];
    assign evt_time_o  = w_empty ? '0 : w_head[TS_W-1:0];
    assign total_cnt_o = r_cnt;
    assign sticky_o    = r_sticky;
    assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_mmr_mismatch_monitor.sv
// Bench for mmr_mismatch_monitor: scoreboarded event stream,
// table of count/sticky vectors and corner-case sequences.
module tb_mmr_mismatch_monitor;
    import mmr_monitor_pkg::*;

    localparam int N  = 8;
    localparam int CW = 4;
    localparam int TW = 16;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          ready;
    logic [N-1:0]  mm;
    logic          evt_valid;
    logic [2:0]    evt_src;
    logic [TW-1:0] evt_time;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sticky;
    logic          ovf;

    always #5 clk = ~clk;

    mmr_mismatch_monitor #(
        .N_SRC (N),
        .CNT_W (CW),
        .TS_W  (TW),
        .DEPTH (D)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .mismatch_i  (mm),
        .clear_i     (clear),
        .evt_valid_o (evt_valid),
        .evt_ready_i (ready),
        .evt_src_o   (evt_src),
        .evt_time_o  (evt_time),
        .total_cnt_o (cnt),
        .sticky_o    (sticky),
        .overflow_o  (ovf)
    );

    // Reference timestamp: zero in reset, +1 on every other edge.
    logic [TW-1:0] tb_ts;
    always @(posedge clk) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + TW'(1);
    end

    evt_t sb[$];
    evt_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;

    typedef struct {
        logic [N-1:0]  pat;
        logic          clr;
        logic [CW-1:0] cnt;
        logic [N-1:0]  sticky;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic exp_evt(input int s, input logic [TW-1:0] t);
        evt_t e;
        e.src    = 3'(s);
        e.tstamp = t;
        sb.push_back(e);
    endtask

    // Rises seen at the next edge, drained one per cycle in index order.
    task automatic push_rises(input logic [N-1:0] p);
        int k;
        k = 0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                exp_evt(i, tb_ts + TW'(1) + TW'(k));
                k++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && evt_valid && ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_evt: got src %0d time %0d want none",
                         evt_src, evt_time);
            end else begin
                mon_e = sb.pop_front();
                chk("evt_src", 32'(evt_src), 32'(mon_e.src));
                chk("evt_time", 32'(evt_time), 32'(mon_e.tstamp));
            end
        end
    end

    logic [TW-1:0] x;

    initial begin
        tbl[0] = '{8'h62, 1'b1, 4'd3, 8'h62};
        tbl[1] = '{8'h81, 1'b0, 4'd5, 8'hE3};
        tbl[2] = '{8'h10, 1'b1, 4'd1, 8'h10};
        tbl[3] = '{8'h0F, 1'b0, 4'd5, 8'h1F};
        tbl[4] = '{8'h00, 1'b1, 4'd0, 8'h00};
        tbl[5] = '{8'hFF, 1'b0, 4'd8, 8'hFF};

        rst_n = 1'b0;
        mm    = '0;
        clear = 1'b0;
        ready = 1'b1;
        ticks(3);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_sticky", 32'(sticky), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        tick();

        // Single rise on src 3, latency and held-high behaviour
        x  = tb_ts;
        mm = 8'h08;
        exp_evt(3, x + TW'(1));
        tick();
        chk("t1_valid_e0", 32'(evt_valid), 0);
        tick();
        chk("t1_valid_e1", 32'(evt_valid), 1);
        chk("t1_src", 32'(evt_src), 3);
        chk("t1_time", 32'(evt_time), 32'(x + TW'(1)));
        ticks(8);
        chk("t1_cnt", 32'(cnt), 1);
        chk("t1_sticky", 32'(sticky), 32'h08);
        chk("t1_drained", sb.size(), 0);
        mm = '0;
        tick();

        for (int v = 0; v < 6; v++) begin
            mm    = tbl[v].pat;
            clear = tbl[v].clr;
            push_rises(tbl[v].pat);
            tick();
            mm    = '0;
            clear = 1'b0;
            ticks(11);
            chk("tbl_cnt", 32'(cnt), 32'(tbl[v].cnt));
            chk("tbl_sticky", 32'(sticky), 32'(tbl[v].sticky));
            chk("tbl_ovf", 32'(ovf), 0);
            chk("tbl_drained", sb.size(), 0);
        end

        // Full queue holds the ninth rise pending, released by one pop
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ready = 1'b0;
        mm    = 8'hFF;
        push_rises(8'hFF);
        ticks(10);
        mm = 8'hFE;
        tick();
        mm = 8'hFF;
        ticks(3);
        chk("t3_valid", 32'(evt_valid), 1);
        chk("t3_held", sb.size(), 8);
        x     = tb_ts;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        exp_evt(0, x + TW'(1));
        ticks(3);
        chk("t3_one_pop", sb.size(), 8);
        ready = 1'b1;
        ticks(12);
        chk("t3_drained", sb.size(), 0);
        chk("t3_empty", 32'(evt_valid), 0);
        chk("t3_cnt", 32'(cnt), 9);
        chk("t3_ovf", 32'(ovf), 0);

        // Double rise on src 2 while its event is held pending
        mm    = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ready = 1'b0;
        mm    = 8'hFF;
        push_rises(8'hFF);
        ticks(10);
        mm = 8'hFB;
        tick();
        mm = 8'hFF;
        tick();
        chk("t4_ovf_first", 32'(ovf), 0);
        mm = 8'hFB;
        tick();
        mm = 8'hFF;
        ticks(2);
        chk("t4_ovf", 32'(ovf), 1);
        chk("t4_cnt", 32'(cnt), 10);
        x     = tb_ts;
        ready = 1'b1;
        exp_evt(2, x + TW'(1));
        ticks(12);
        chk("t4_drained", sb.size(), 0);
        chk("t4_empty", 32'(evt_valid), 0);

        // Counter saturation, then clear racing a rise
        mm    = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_ovf_clr", 32'(ovf), 0);
        repeat (20) begin
            mm = 8'h01;
            exp_evt(0, tb_ts + TW'(1));
            tick();
            mm = '0;
            tick();
        end
        ticks(4);
        chk("t5_sat", 32'(cnt), 15);
        chk("t5_sticky", 32'(sticky), 32'h01);
        chk("t5_drained", sb.size(), 0);
        sticky_check_pre: begin
            mm    = 8'h01;
            clear = 1'b1;
            exp_evt(0, tb_ts + TW'(1));
            tick();
        end
        clear = 1'b0;
        mm    = '0;
        chk("t5_clr_cnt", 32'(cnt), 1);
        chk("t5_clr_sticky", 32'(sticky), 32'h01);
        ticks(4);
        chk("t5_drained2", sb.size(), 0);

        // Reset mid-stream with src 4 held high
        ready = 1'b0;
        mm    = 8'h13;
        ticks(6);
        chk("t6_queued", 32'(evt_valid), 1);
        rst_n = 1'b0;
        mm    = 8'h10;
        ticks(2);
        sb.delete();
        chk("t6_valid", 32'(evt_valid), 0);
        chk("t6_cnt", 32'(cnt), 0);
        chk("t6_sticky", 32'(sticky), 0);
        chk("t6_ovf", 32'(ovf), 0);
        chk("t6_src", 32'(evt_src), 0);
        chk("t6_time", 32'(evt_time), 0);
        rst_n = 1'b1;
        tick();
        chk("t6_valid_e0", 32'(evt_valid), 0);
        tick();
        chk("t6_valid_e1", 32'(evt_valid), 1);
        chk("t6_src4", 32'(evt_src), 4);
        chk("t6_time1", 32'(evt_time), 1);
        exp_evt(4, TW'(1));
        ready = 1'b1;
        ticks(6);
        chk("t6_drained", sb.size(), 0);
        chk("t6_once", 32'(evt_valid), 0);
        chk("t6_cnt1", 32'(cnt), 1);
        chk("t6_sticky4", 32'(sticky), 32'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
